// File: rtl/alu_program_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_program_sequencer_pkg
// Purpose  : Shared opcodes, flag indices and FSM encoding for the sequencer.
// Revision : 1.0
// ============================================================================
package alu_program_sequencer_pkg;

    localparam logic [3:0] OPC_LOADI = 4'h0;
    localparam logic [3:0] OPC_ALU   = 4'h1;  // must track the datapath's ALU decode
    localparam logic [3:0] OPC_JMP   = 4'h2;
    localparam logic [3:0] OPC_BRF   = 4'h3;
    localparam logic [3:0] OPC_HALT  = 4'hF;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam logic [15:0] IDLE_OP_DEFAULT = 16'hE000;

    localparam logic [1:0] NPC_INC    = 2'd0;
    localparam logic [1:0] NPC_TARGET = 2'd1;
    localparam logic [1:0] NPC_HOLD   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_seq_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_decoder
// Purpose  : Combinational decode of an instruction word plus ALU flags.
// Revision : 1.0
// ============================================================================
module alu_seq_decoder
    import alu_program_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [31:0]       instr,
    input  logic [3:0]        flags,
    output logic              issue,
    output logic              is_alu,
    output logic              is_halt,
    output logic [1:0]        next_pc_sel,
    output logic [ADDR_W-1:0] target
);

    logic [3:0] w_class;
    logic [3:0] w_mask;
    logic       w_unused_fields;

    assign w_class         = instr[31:28];
    assign w_mask          = instr[19:16];
    assign target          = instr[ADDR_W-1:0];
    assign w_unused_fields = ^instr[27:20];

    if (ADDR_W < 16) begin : g_unused_operand
        logic w_unused_operand;
        assign w_unused_operand = ^instr[15:ADDR_W];
    end

    always_comb begin
        issue       = 1'b0;
        is_alu      = 1'b0;
        is_halt     = 1'b0;
        next_pc_sel = NPC_INC;
        case (w_class)
            OPC_LOADI: issue = 1'b1;
            OPC_ALU: begin
                issue  = 1'b1;
                is_alu = 1'b1;
            end
            OPC_JMP: next_pc_sel = NPC_TARGET;
            OPC_BRF: next_pc_sel = ((flags & w_mask) != 4'h0) ? NPC_TARGET : NPC_INC;
            OPC_HALT: begin
                is_halt     = 1'b1;
                next_pc_sel = NPC_HOLD;
            end
            default: next_pc_sel = NPC_INC;  // unknown classes behave as NOP
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_program_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_program_sequencer
// Purpose  : Fetches instructions and issues them to the ALU datapath.
// Revision : 1.0
// ============================================================================
module alu_program_sequencer
    import alu_program_sequencer_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter int          ALU_LATENCY = 1,
    parameter logic [15:0] IDLE_OP     = IDLE_OP_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_pc,
    input  logic              stop,
    output logic              busy,
    output logic              done,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_data,
    output logic [15:0]       operator,
    output logic [15:0]       operand,
    input  logic [3:0]        alu_flags,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       retired
);

    localparam logic [3:0] c_wait_init = 4'(ALU_LATENCY);

    state_t            r_state;
    logic [3:0]        r_wait_cnt;
    logic              w_issue;
    logic              w_is_alu;
    logic              w_is_halt;
    logic [1:0]        w_npc_sel;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_next_pc;

    alu_seq_decoder #(
        .ADDR_W(ADDR_W)
    ) u_decoder (
        .instr      (imem_data),
        .flags      (alu_flags),
        .issue      (w_issue),
        .is_alu     (w_is_alu),
        .is_halt    (w_is_halt),
        .next_pc_sel(w_npc_sel),
        .target     (w_target)
    );

    always_comb begin
        case (w_npc_sel)
            NPC_TARGET: w_next_pc = w_target;
            NPC_HOLD:   w_next_pc = pc;
            default:    w_next_pc = pc + ADDR_W'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 4'h0;
            pc         <= '0;
            retired    <= 16'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            imem_en    <= 1'b0;
            imem_addr  <= '0;
            operator   <= IDLE_OP;
            operand    <= 16'h0;
        end else begin
            done     <= 1'b0;
            imem_en  <= 1'b0;
            operator <= IDLE_OP;
            operand  <= 16'h0;
            // An issue decoded this cycle goes out even if stop aborts the run.
            if (r_state == ST_DECODE && w_issue) begin
                operator <= imem_data[31:16];
                operand  <= imem_data[15:0];
            end
            if (stop && r_state != ST_IDLE) begin
                r_state <= ST_IDLE;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start && !stop) begin
                            pc        <= start_pc;
                            retired   <= 16'h0;
                            busy      <= 1'b1;
                            imem_en   <= 1'b1;
                            imem_addr <= start_pc;
                            r_state   <= ST_FETCH;
                        end
                    end
                    ST_FETCH: r_state <= ST_DECODE;
                    ST_DECODE: begin
                        pc <= w_next_pc;
                        if (!w_is_halt) begin
                            retired <= retired + 16'h1;
                        end
                        if (w_is_halt) begin
                            done    <= 1'b1;
                            r_state <= ST_HALT;
                        end else if (w_is_alu) begin
                            r_wait_cnt <= c_wait_init;
                            r_state    <= ST_WAIT;
                        end else begin
                            imem_en   <= 1'b1;
                            imem_addr <= w_next_pc;
                            r_state   <= ST_FETCH;
                        end
                    end
                    ST_WAIT: begin
                        if (r_wait_cnt <= 4'h1) begin
                            imem_en   <= 1'b1;
                            imem_addr <= pc;
                            r_state   <= ST_FETCH;
                        end else begin
                            r_wait_cnt <= r_wait_cnt - 4'h1;
                        end
                    end
                    ST_HALT: begin
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_program_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_alu_program_sequencer
// Purpose  : Self-checking bench: vector table, directed corners, random runs.
// Revision : 1.0
// ============================================================================
module tb_alu_program_sequencer;

    localparam logic [15:0] IDLE = 16'hE000;

    typedef struct packed {
        logic        en;
        logic [7:0]  addr;
        logic [15:0] op;
        logic [15:0] opd;
        logic        dn;
        logic        bsy;
        logic [7:0]  pcv;
        logic [15:0] ret;
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  at;
        logic [3:0]  fl;
        logic [7:0]  exp_pc;
        logic [15:0] exp_op;
        logic [15:0] exp_opd;
        logic        exp_done;
        logic [15:0] exp_ret;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, stop, start3, stop3, flags_load;
    logic [7:0]  start_pc;
    logic [3:0]  flags, flags3, flags_val;
    logic        busy, done, imem_en, busy3, done3, imem_en3;
    logic [7:0]  imem_addr, pc, imem_addr3, pc3;
    logic [31:0] imem_data, imem_data3;
    logic [15:0] operator, operand, retired, operator3, operand3, retired3;
    logic [31:0] mem [0:255];
    obs_t        obs1, exp_q[$];
    int          n_pass = 0, n_total = 0;

    alu_program_sequencer #(.ADDR_W(8), .ALU_LATENCY(1), .IDLE_OP(16'hE000)) dut (
        .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .stop(stop),
        .busy(busy), .done(done), .imem_en(imem_en), .imem_addr(imem_addr),
        .imem_data(imem_data), .operator(operator), .operand(operand),
        .alu_flags(flags), .pc(pc), .retired(retired));

    alu_program_sequencer #(.ADDR_W(8), .ALU_LATENCY(3), .IDLE_OP(16'hE000)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .start_pc(start_pc), .stop(stop3),
        .busy(busy3), .done(done3), .imem_en(imem_en3), .imem_addr(imem_addr3),
        .imem_data(imem_data3), .operator(operator3), .operand(operand3),
        .alu_flags(flags3), .pc(pc3), .retired(retired3));

    assign obs1 = {imem_en, imem_addr, operator, operand, done, busy, pc, retired};

    // Synchronous instruction memories and a toy datapath: an ALU issue sets flags to operand[3:0].
    always @(posedge clk) begin
        if (imem_en)  imem_data  <= mem[imem_addr];
        if (imem_en3) imem_data3 <= mem[imem_addr3];
        if (reset) begin
            flags  <= 4'h0;
            flags3 <= 4'h0;
        end else begin
            if (flags_load)                    flags  <= flags_val;
            else if (operator[15:12] == 4'h1)  flags  <= operand[3:0];
            if (operator3[15:12] == 4'h1)      flags3 <= operand3[3:0];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_flags(input logic [3:0] v);
        flags_val  = v;
        flags_load = 1'b1;
        tick;
        flags_load = 1'b0;
    endtask

    function automatic obs_t mk(input logic en, input logic [7:0] a, input logic [15:0] op,
                                input logic [15:0] opd, input logic dn, input logic b,
                                input logic [7:0] p, input logic [15:0] r);
        return {en, a, op, opd, dn, b, p, r};
    endfunction

    // Instruction-level reference: each instruction expands into its expected cycles.
    task automatic build_trace(input logic [7:0] sp, input int maxc, output bit halted);
        logic [7:0]  p;
        logic [15:0] ret, pop, popd;
        logic [3:0]  fl;
        logic [31:0] w;
        bit          pend;
        exp_q.delete();
        p = sp; ret = 16'h0; fl = flags; pend = 1'b0; halted = 1'b0;
        pop = IDLE; popd = 16'h0;
        while (!halted && exp_q.size() < maxc) begin
            w = mem[p];
            exp_q.push_back(mk(1'b1, p, pend ? pop : IDLE, pend ? popd : 16'h0, 1'b0, 1'b1, p, ret));
            pend = 1'b0;
            exp_q.push_back(mk(1'b0, p, IDLE, 16'h0, 1'b0, 1'b1, p, ret));
            case (w[31:28])
                4'h0: begin
                    pend = 1'b1; pop = w[31:16]; popd = w[15:0];
                    p = p + 8'd1; ret = ret + 16'd1;
                end
                4'h1: begin
                    exp_q.push_back(mk(1'b0, p, w[31:16], w[15:0], 1'b0, 1'b1, p + 8'd1, ret + 16'd1));
                    fl = w[3:0]; p = p + 8'd1; ret = ret + 16'd1;
                end
                4'h2: begin p = w[7:0]; ret = ret + 16'd1; end
                4'h3: begin
                    p = ((fl & w[19:16]) != 4'h0) ? w[7:0] : p + 8'd1;
                    ret = ret + 16'd1;
                end
                4'hF: begin
                    exp_q.push_back(mk(1'b0, p, IDLE, 16'h0, 1'b1, 1'b1, p, ret));
                    exp_q.push_back(mk(1'b0, p, IDLE, 16'h0, 1'b0, 1'b0, p, ret));
                    halted = 1'b1;
                end
                default: begin p = p + 8'd1; ret = ret + 16'd1; end
            endcase
        end
    endtask

    task automatic run_model(input string tag, input logic [7:0] sp, input int maxc);
        bit halted;
        build_trace(sp, maxc, halted);
        start_pc = sp; start = 1'b1;
        tick;
        start = 1'b0;
        foreach (exp_q[i]) begin
            check($sformatf("%s_cyc%0d", tag, i), obs1, exp_q[i]);
            tick;
        end
        if (!halted) begin
            stop = 1'b1;
            tick;
            stop = 1'b0;
            check({tag, "_stop"}, {busy, done, imem_en}, 3'b000);
            tick;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        int unsigned r;
        r = $urandom_range(0, 15);
        if (r <= 3)       return {4'h0, 12'($urandom), 16'($urandom)};
        else if (r <= 6)  return {4'h1, 12'($urandom), 16'($urandom)};
        else if (r <= 8)  return {4'h2, 12'($urandom), 16'($urandom)};
        else if (r <= 11) return {4'h3, 12'($urandom), 16'($urandom)};
        else if (r == 12) return {4'hF, 28'($urandom)};
        else              return {4'($urandom_range(4, 14)), 28'($urandom)};
    endfunction

    vec_t        vecs [12];
    int          enc, done_k, first_en, second_en, alu_cnt;
    logic        busy_after;
    logic [15:0] ret_at_done, r_snap;

    initial begin
        vecs[0]  = '{32'h0001_0005, 8'h30, 4'h0, 8'h31, 16'h0001, 16'h0005, 1'b0, 16'd1};
        vecs[1]  = '{32'h1234_00A0, 8'h31, 4'h0, 8'h32, 16'h1234, 16'h00A0, 1'b0, 16'd1};
        vecs[2]  = '{32'h2000_0077, 8'h40, 4'h0, 8'h77, IDLE,     16'h0000, 1'b0, 16'd1};
        vecs[3]  = '{32'h3001_0055, 8'h50, 4'h1, 8'h55, IDLE,     16'h0000, 1'b0, 16'd1};
        vecs[4]  = '{32'h3001_0055, 8'h50, 4'hE, 8'h51, IDLE,     16'h0000, 1'b0, 16'd1};
        vecs[5]  = '{32'h3008_0066, 8'h52, 4'h8, 8'h66, IDLE,     16'h0000, 1'b0, 16'd1};
        vecs[6]  = '{32'h3000_0066, 8'h53, 4'hF, 8'h54, IDLE,     16'h0000, 1'b0, 16'd1};
        vecs[7]  = '{32'h5000_0000, 8'hFF, 4'h0, 8'h00, IDLE,     16'h0000, 1'b0, 16'd1};
        vecs[8]  = '{32'hF000_0000, 8'h60, 4'h0, 8'h60, IDLE,     16'h0000, 1'b1, 16'd0};
        vecs[9]  = '{32'h2000_0061, 8'h61, 4'h0, 8'h61, IDLE,     16'h0000, 1'b0, 16'd1};
        vecs[10] = '{32'hE123_4567, 8'h70, 4'h0, 8'h71, IDLE,     16'h0000, 1'b0, 16'd1};
        vecs[11] = '{32'h2000_AB12, 8'h72, 4'h0, 8'h12, IDLE,     16'h0000, 1'b0, 16'd1};

        for (int a = 0; a < 256; a++) mem[a] = 32'h5000_0000;
        reset = 1'b1; start = 1'b0; stop = 1'b0; start3 = 1'b0; stop3 = 1'b0;
        flags_load = 1'b0; flags_val = 4'h0; start_pc = 8'h00;
        tick; tick;
        check("reset_dut", obs1, mk(1'b0, 8'h00, IDLE, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0));
        check("reset_dut3", {imem_en3, imem_addr3, operator3, operand3, done3, busy3, pc3, retired3},
              mk(1'b0, 8'h00, IDLE, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0));
        reset = 1'b0;
        tick;

        // Single-instruction vectors observed two cycles after the fetch.
        foreach (vecs[i]) begin
            mem[vecs[i].at] = vecs[i].instr;
            set_flags(vecs[i].fl);
            start_pc = vecs[i].at; start = 1'b1;
            tick;
            start = 1'b0;
            tick; tick;
            check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_bus", i), {operator, operand, done, retired},
                  {vecs[i].exp_op, vecs[i].exp_opd, vecs[i].exp_done, vecs[i].exp_ret});
            stop = 1'b1;
            tick;
            stop = 1'b0;
            check($sformatf("vec%0d_stop", i), {busy, done}, 2'b00);
            tick;
        end

        // Straight-line program: issue timing, done pulse and retired count.
        mem[0] = 32'h0001_0005; mem[1] = 32'h0002_0003; mem[2] = 32'h1012_0000; mem[3] = 32'hF000_0000;
        set_flags(4'h0);
        start_pc = 8'h00; start = 1'b1;
        tick;
        start = 1'b0;
        enc = 0; done_k = -1; busy_after = 1'b1; ret_at_done = 16'hFFFF;
        for (int k = 0; k < 14; k++) begin
            if (operator !== IDLE) enc = enc * 16 + k;
            if (done === 1'b1) begin done_k = k; ret_at_done = retired; end
            if (done_k >= 0 && k == done_k + 1) busy_after = busy;
            tick;
        end
        check("sl_issue_cycles", enc, 32'h246);
        check("sl_done_cycle", done_k, 9);
        check("sl_retired", ret_at_done, 16'd3);
        check("sl_busy_after", busy_after, 1'b0);
        run_model("sl_model", 8'h00, 40);

        // Branch taken on Z set by the preceding ALU op, then not taken with Z clear.
        mem[8'h10] = 32'h1000_0001; mem[8'h11] = 32'h3001_0020;
        mem[8'h12] = 32'hF000_0000; mem[8'h20] = 32'hF000_0000;
        for (int z = 1; z >= 0; z--) begin
            mem[8'h10] = {16'h1000, 15'h0, z[0]};
            set_flags(4'h0);
            start_pc = 8'h10; start = 1'b1;
            tick;
            start = 1'b0;
            for (int k = 0; k < 5; k++) tick;
            check($sformatf("brf_z%0d_pc", z), pc, z ? 8'h20 : 8'h12);
            check($sformatf("brf_z%0d_fetch", z), {imem_en, imem_addr}, {1'b1, z ? 8'h20 : 8'h12});
            stop = 1'b1; tick; stop = 1'b0; tick;
        end

        // Wrap from 0xFF into a self-jump at 0x00.
        mem[8'hFF] = 32'h5000_0000; mem[8'h00] = 32'h2000_0000;
        start_pc = 8'hFF; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        check("wrap_fetch", {imem_en, imem_addr}, {1'b1, 8'h00});
        alu_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            if (operator !== IDLE) alu_cnt++;
            tick;
        end
        check("selfloop_idle_op", alu_cnt, 0);
        stop = 1'b1; tick; stop = 1'b0;
        check("selfloop_stop", {busy, done}, 2'b00);
        tick;

        // Latency 3: WAIT length, single-cycle issue and done position.
        mem[8'h80] = 32'h1ABC_0000; mem[8'h81] = 32'hF000_0000;
        start_pc = 8'h80; start3 = 1'b1;
        tick;
        start3 = 1'b0;
        first_en = -1; second_en = -1; alu_cnt = 0; done_k = -1;
        for (int k = 0; k < 12; k++) begin
            if (imem_en3 === 1'b1) begin
                if (first_en < 0) first_en = k;
                else if (second_en < 0) second_en = k;
            end
            if (operator3 === 16'h1ABC) alu_cnt++;
            if (done3 === 1'b1) done_k = k;
            tick;
        end
        check("lat_wait_cycles", second_en - first_en - 2, 3);
        check("lat_issue_cycles", alu_cnt, 1);
        check("lat_done_cycle", done_k, 7);

        // Reset while in WAIT.
        mem[8'h90] = 32'h1000_0003;
        start_pc = 8'h90; start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        reset = 1'b1;
        tick;
        check("reset_in_wait", obs1, mk(1'b0, 8'h00, IDLE, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0));
        reset = 1'b0;
        tick;

        // start and stop together in IDLE.
        start_pc = 8'h40; start = 1'b1; stop = 1'b1;
        tick;
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", {busy, imem_en}, 2'b00);
        tick;
        check("start_stop_idle2", {busy, imem_en, pc}, {1'b0, 1'b0, 8'h00});

        // start while busy is ignored.
        mem[8'hA0] = 32'h2000_00A0;
        start_pc = 8'hA0; start = 1'b1;
        tick;
        start = 1'b0;
        for (int k = 0; k < 6; k++) tick;
        r_snap = retired;
        start_pc = 8'h40; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        check("start_busy_retired", retired, r_snap + 16'd1);
        check("start_busy_pc", pc, 8'hA0);
        stop = 1'b1; tick; stop = 1'b0; tick;

        // Random programs against the instruction-level reference.
        for (int t = 0; t < 25; t++) begin
            for (int a = 0; a < 256; a++) mem[a] = rand_instr();
            set_flags(4'($urandom));
            run_model($sformatf("rnd%0d", t), 8'($urandom), 60);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
